// File: rtl/demux2reg_stream_if.sv
// Handshake bundle for the registered 1-to-2 stream demultiplexer: one producer
// port and two consumer ports.
interface demux2reg_stream_if #(
  parameter int BITS = 3
);
  logic            enable;
  logic            mode;
  logic            select;
  logic [BITS-1:0] in_data;
  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] out_a;
  logic            valid_a;
  logic            ready_a;
  logic [BITS-1:0] out_b;
  logic            valid_b;
  logic            ready_b;
  logic            next_sel;

  // Producer and consumer side: drives the stream inputs and both ready lines.
  modport master (
    output enable, mode, select, in_data, in_valid, ready_a, ready_b,
    input  in_ready, out_a, valid_a, out_b, valid_b, next_sel
  );

  // Demultiplexer side.
  modport slave (
    input  enable, mode, select, in_data, in_valid, ready_a, ready_b,
    output in_ready, out_a, valid_a, out_b, valid_b, next_sel
  );
endinterface

// File: rtl/demux2reg_stream.sv
// Registered 1-to-2 stream demultiplexer. Each input word goes to port A or B,
// chosen by an explicit select or by a ping-pong toggle, with valid/ready on every port.

// Single data bit flop with load enable; clears on asynchronous reset.
module demux2reg_stream_act_cell (
  input  logic clock,
  input  logic reset,
  input  logic en,
  input  logic d,
  output logic q
);
  // Bit storage: load when enabled, otherwise hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end else begin
      q <= q;
    end
  end
endmodule

module demux2reg_stream #(
  parameter int BITS = 3
) (
  input logic               clock,
  input logic               reset,
  demux2reg_stream_if.slave bus
);
  logic            toggle_r;
  logic            valid_a_r;
  logic            valid_b_r;
  logic [BITS-1:0] out_a_r;
  logic [BITS-1:0] out_b_r;

  logic            next_sel_s;
  logic            free_a_s;
  logic            free_b_s;
  logic            in_ready_s;
  logic            accept_s;
  logic            load_a_s;
  logic            load_b_s;
  logic            valid_a_nxt_s;
  logic            valid_b_nxt_s;
  logic            toggle_nxt_s;

  // Target selection and handshake decode. A busy target never redirects
  // the word to the other port; the producer simply stalls.
  always_comb begin
    next_sel_s = 1'b0;
    free_a_s   = 1'b0;
    free_b_s   = 1'b0;
    in_ready_s = 1'b0;
    accept_s   = 1'b0;
    load_a_s   = 1'b0;
    load_b_s   = 1'b0;

    if (bus.mode) begin
      next_sel_s = toggle_r;
    end else begin
      next_sel_s = bus.select;
    end

    free_a_s = (~valid_a_r) | bus.ready_a;
    free_b_s = (~valid_b_r) | bus.ready_b;

    case (next_sel_s)
      1'b0:    in_ready_s = bus.enable & free_a_s;
      1'b1:    in_ready_s = bus.enable & free_b_s;
      default: in_ready_s = 1'b0;
    endcase

    accept_s = bus.in_valid & in_ready_s;
    load_a_s = accept_s & ~next_sel_s;
    load_b_s = accept_s & next_sel_s;
  end

  // Next-state for the valid flags and the toggle; a load beats a drain.
  always_comb begin
    valid_a_nxt_s = valid_a_r;
    valid_b_nxt_s = valid_b_r;
    toggle_nxt_s  = toggle_r;

    if (load_a_s) begin
      valid_a_nxt_s = 1'b1;
    end else if (bus.ready_a) begin
      valid_a_nxt_s = 1'b0;
    end else begin
      valid_a_nxt_s = valid_a_r;
    end

    if (load_b_s) begin
      valid_b_nxt_s = 1'b1;
    end else if (bus.ready_b) begin
      valid_b_nxt_s = 1'b0;
    end else begin
      valid_b_nxt_s = valid_b_r;
    end

    if (accept_s && bus.mode) begin
      toggle_nxt_s = ~toggle_r;
    end else begin
      toggle_nxt_s = toggle_r;
    end
  end

  // Control state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_a_r <= 1'b0;
      valid_b_r <= 1'b0;
      toggle_r  <= 1'b0;
    end else begin
      valid_a_r <= valid_a_nxt_s;
      valid_b_r <= valid_b_nxt_s;
      toggle_r  <= toggle_nxt_s;
    end
  end

  // Per-bit data storage; data is kept after a drain, only replaced on a load.
  for (genvar i = 0; i < BITS; i++) begin : g_bit
    demux2reg_stream_act_cell u_cell_a (
      .clock (clock),
      .reset (reset),
      .en    (load_a_s),
      .d     (bus.in_data[i]),
      .q     (out_a_r[i])
    );
    demux2reg_stream_act_cell u_cell_b (
      .clock (clock),
      .reset (reset),
      .en    (load_b_s),
      .d     (bus.in_data[i]),
      .q     (out_b_r[i])
    );
  end

  assign bus.out_a    = out_a_r;
  assign bus.valid_a  = valid_a_r;
  assign bus.out_b    = out_b_r;
  assign bus.valid_b  = valid_b_r;
  assign bus.in_ready = in_ready_s;
  assign bus.next_sel = next_sel_s;
endmodule
